// File: rtl/btn_debounce.sv
// Push-button conditioner: two-flop synchroniser, press/release debounce FSM,
// and single-cycle press, release and long-press strobes with a clean level.
module btn_debounce #(
   parameter int unsigned DEBOUNCE_CYCLES = 500000,
   parameter int unsigned LONG_CYCLES     = 50000000,
   parameter int unsigned CNT_W           = 26
) (
   input  logic CLK,
   input  logic RST_N,
   input  logic BTN_RAW,
   output logic BTN_LEVEL,
   output logic BTN_PULSE,
   output logic BTN_RELEASE,
   output logic BTN_LONG
);

   typedef enum logic [1:0] {StIdle, StPWait, StHeld, StRWait} state_t;

   localparam logic [CNT_W-1:0] db_last   = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [CNT_W-1:0] long_last = CNT_W'(LONG_CYCLES - 1);
   localparam logic [CNT_W-1:0] long_max  = CNT_W'(LONG_CYCLES);

   state_t           state;
   logic             s1, s2;
   logic [CNT_W-1:0] dcnt;
   logic [CNT_W-1:0] lcnt;
   logic             long_done;
   logic             rel_accept;

   // A release accepted on the same edge that would fire the long strobe wins.
   assign rel_accept = (state == StRWait) && !s2 && (dcnt == db_last);

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state       <= StIdle;
         s1          <= 1'b0;
         s2          <= 1'b0;
         dcnt        <= '0;
         lcnt        <= '0;
         long_done   <= 1'b0;
         BTN_LEVEL   <= 1'b0;
         BTN_PULSE   <= 1'b0;
         BTN_RELEASE <= 1'b0;
         BTN_LONG    <= 1'b0;
      end else begin
         s1          <= BTN_RAW;
         s2          <= s1;
         BTN_PULSE   <= 1'b0;
         BTN_RELEASE <= 1'b0;
         BTN_LONG    <= 1'b0;

         if (state == StHeld || state == StRWait) begin
            if (lcnt != long_max) lcnt <= lcnt + 1'b1;
            if (lcnt == long_last && !long_done && !rel_accept) begin
               BTN_LONG  <= 1'b1;
               long_done <= 1'b1;
            end
         end

         unique case (state)
            StIdle: begin
               if (s2) begin
                  state <= StPWait;
                  dcnt  <= CNT_W'(1);
               end
            end
            StPWait: begin
               if (!s2) begin
                  state <= StIdle;
                  dcnt  <= '0;
               end else if (dcnt == db_last) begin
                  state     <= StHeld;
                  dcnt      <= '0;
                  BTN_LEVEL <= 1'b1;
                  BTN_PULSE <= 1'b1;
                  lcnt      <= '0;
                  long_done <= 1'b0;
               end else begin
                  dcnt <= dcnt + 1'b1;
               end
            end
            StHeld: begin
               if (!s2) begin
                  state <= StRWait;
                  dcnt  <= CNT_W'(1);
               end
            end
            StRWait: begin
               if (s2) begin
                  state <= StHeld;
                  dcnt  <= '0;
               end else if (dcnt == db_last) begin
                  state       <= StIdle;
                  dcnt        <= '0;
                  BTN_LEVEL   <= 1'b0;
                  BTN_RELEASE <= 1'b1;
               end else begin
                  dcnt <= dcnt + 1'b1;
               end
            end
            default: state <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_btn_debounce.sv
// Scoreboard bench for btn_debounce: stimulus queues expected strobes with their
// edge index; a negedge monitor pops and compares whenever a strobe is seen.
module tb_btn_debounce;

   localparam int unsigned DB = 4;
   localparam int unsigned LG = 20;
   localparam int unsigned W  = 8;

   logic CLK = 1'b0;
   logic RST_N = 1'b0;
   logic BTN_RAW = 1'b0;
   logic BTN_LEVEL, BTN_PULSE, BTN_RELEASE, BTN_LONG;

   btn_debounce #(
      .DEBOUNCE_CYCLES(DB),
      .LONG_CYCLES    (LG),
      .CNT_W          (W)
   ) dut (
      .CLK        (CLK),
      .RST_N      (RST_N),
      .BTN_RAW    (BTN_RAW),
      .BTN_LEVEL  (BTN_LEVEL),
      .BTN_PULSE  (BTN_PULSE),
      .BTN_RELEASE(BTN_RELEASE),
      .BTN_LONG   (BTN_LONG)
   );

   always #5 CLK = ~CLK;

   // Number of rising edges so far; read only at negedges.
   int edge_cnt = 0;
   always @(posedge CLK) edge_cnt++;

   int total = 0;
   int bad = 0;

   typedef struct {
      int kind;
      int at;
   } ev_t;
   ev_t exp_q[$];
   string names[3] = '{"pulse", "release", "long"};

   task automatic expect_ev(input int kind, input int at);
      ev_t e;
      e.kind = kind;
      e.at   = at;
      exp_q.push_back(e);
   endtask

   task automatic check_strobe(input int kind);
      ev_t e;
      total++;
      if (exp_q.size() == 0) begin
         bad++;
         $display("FAIL unexpected_%s: got strobe after edge %0d, required none",
                  names[kind], edge_cnt);
      end else begin
         e = exp_q.pop_front();
         if (e.kind != kind || e.at != edge_cnt) begin
            bad++;
            $display("FAIL strobe: got %s after edge %0d, required %s after edge %0d",
                     names[kind], edge_cnt, names[e.kind], e.at);
         end
      end
   endtask

   task automatic check_bit(input string name, input logic got, input logic want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s: got %b, required %b (edge %0d)", name, got, want, edge_cnt);
      end
   endtask

   task automatic to_edge(input int n);
      while (edge_cnt < n) @(negedge CLK);
   endtask

   always @(negedge CLK) begin
      if (BTN_PULSE)   check_strobe(0);
      if (BTN_RELEASE) check_strobe(1);
      if (BTN_LONG)    check_strobe(2);
   end

   initial begin
      int e, p, r;
      logic [4:0] pat;

      repeat (3) @(negedge CLK);
      check_bit("reset_level", BTN_LEVEL, 1'b0);
      check_bit("reset_pulse", BTN_PULSE, 1'b0);
      check_bit("reset_release", BTN_RELEASE, 1'b0);
      check_bit("reset_long", BTN_LONG, 1'b0);
      RST_N = 1'b1;
      @(negedge CLK);

      // Clean press held well past the long-press point.
      BTN_RAW = 1'b1;
      e = edge_cnt + 1;
      expect_ev(0, e + 5);
      expect_ev(2, e + 5 + 20);
      to_edge(e + 4);
      check_bit("level_before_press", BTN_LEVEL, 1'b0);
      to_edge(e + 5);
      check_bit("level_after_press", BTN_LEVEL, 1'b1);
      to_edge(e + 25 + 100);

      // Two-cycle low glitch while held.
      BTN_RAW = 1'b0;
      repeat (2) @(negedge CLK);
      BTN_RAW = 1'b1;
      repeat (8) @(negedge CLK);
      check_bit("level_after_glitch", BTN_LEVEL, 1'b1);

      // Clean release.
      BTN_RAW = 1'b0;
      r = edge_cnt + 1;
      expect_ev(1, r + 5);
      to_edge(r + 4);
      check_bit("level_before_release", BTN_LEVEL, 1'b1);
      to_edge(r + 5);
      check_bit("level_after_release", BTN_LEVEL, 1'b0);
      repeat (4) @(negedge CLK);

      // Bouncy press, then release accepted on the would-be long-press edge.
      pat = 5'b01101;
      for (int i = 0; i < 5; i++) begin
         BTN_RAW = pat[i];
         @(negedge CLK);
      end
      BTN_RAW = 1'b1;
      e = edge_cnt + 1;
      p = e + 5;
      expect_ev(0, p);
      expect_ev(1, p + 20);
      to_edge(p - 1);
      check_bit("bounce_level_before", BTN_LEVEL, 1'b0);
      to_edge(p);
      check_bit("bounce_level_after", BTN_LEVEL, 1'b1);
      to_edge(p + 14);
      BTN_RAW = 1'b0;
      to_edge(p + 21);
      check_bit("race_level", BTN_LEVEL, 1'b0);
      repeat (4) @(negedge CLK);

      // Asynchronous reset while held, then re-debounce of the still-held button.
      BTN_RAW = 1'b1;
      e = edge_cnt + 1;
      expect_ev(0, e + 5);
      to_edge(e + 7);
      check_bit("held_level", BTN_LEVEL, 1'b1);
      RST_N = 1'b0;
      #1;
      check_bit("async_level", BTN_LEVEL, 1'b0);
      check_bit("async_pulse", BTN_PULSE, 1'b0);
      check_bit("async_release", BTN_RELEASE, 1'b0);
      check_bit("async_long", BTN_LONG, 1'b0);
      repeat (2) @(negedge CLK);
      RST_N = 1'b1;
      e = edge_cnt + 1;
      expect_ev(0, e + 5);
      to_edge(e + 4);
      check_bit("repress_level_before", BTN_LEVEL, 1'b0);
      to_edge(e + 5);
      check_bit("repress_level_after", BTN_LEVEL, 1'b1);
      to_edge(e + 8);
      BTN_RAW = 1'b0;
      r = edge_cnt + 1;
      expect_ev(1, r + 5);
      to_edge(r + 8);
      check_bit("final_level", BTN_LEVEL, 1'b0);

      total++;
      if (exp_q.size() != 0) begin
         bad++;
         $display("FAIL missing_strobes: got %0d still pending, required 0 (next %s at edge %0d)",
                  exp_q.size(), names[exp_q[0].kind], exp_q[0].at);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/btn_debounce.md
Name: btn_debounce

Overview:
- Conditions the raw push-button input before the LED toggle stage, which XORs its LED register with its button input on every clock.
- BTN_PULSE drives that stage's BTN input, so the LED changes exactly once per physical press instead of once per clock while the button is held.
- The block synchronises the raw input, debounces press and release with a stability counter, and emits single-cycle press, release and long-press events plus a clean debounced level.

Parameters:
DEBOUNCE_CYCLES, 500000, consecutive synchronised samples needed to accept a press or a release (10 ms at 50 MHz); legal range >= 2
LONG_CYCLES, 50000000, clock cycles from the BTN_PULSE cycle to the BTN_LONG cycle (1 s at 50 MHz); legal range >= 1
CNT_W, 26, width of both internal counters; must hold LONG_CYCLES and DEBOUNCE_CYCLES

Ports:
CLK  input  1  system clock, rising edge
RST_N  input  1  asynchronous active-low reset
BTN_RAW  input  1  raw asynchronous button, active high, may bounce
BTN_LEVEL  output  1  debounced button level
BTN_PULSE  output  1  one-cycle strobe on accepted press; feeds the LED toggle stage
BTN_RELEASE  output  1  one-cycle strobe on accepted release
BTN_LONG  output  1  one-cycle strobe when a press has been held LONG_CYCLES

Behaviour:
- Reset: RST_N low clears everything immediately, without waiting for a clock edge. That covers both synchroniser flops, dcnt, lcnt, the long_done flag and all outputs, and the FSM returns to IDLE.
- Reset mid-operation: no BTN_RELEASE is generated. After RST_N is released, a still-held button is re-debounced from IDLE.
- Synchroniser: two flops, BTN_RAW -> s1 -> s2. The FSM uses only s2.
- All outputs are registered. The strobes default to 0 on every cycle they are not explicitly set.
- FSM states and transitions:
  - IDLE (level 0): if s2=1, go to P_WAIT with dcnt=1.
  - P_WAIT: if s2=0, go to IDLE with dcnt=0 and no output. If s2=1 and dcnt=DEBOUNCE_CYCLES-1, go to HELD and set BTN_LEVEL<=1, BTN_PULSE<=1, lcnt<=0, long_done<=0. Otherwise dcnt++.
  - HELD: if s2=0, go to R_WAIT with dcnt=1.
  - R_WAIT: if s2=1, return to HELD with dcnt=0, no strobe, and BTN_LEVEL staying 1. If s2=0 and dcnt=DEBOUNCE_CYCLES-1, go to IDLE and set BTN_LEVEL<=0, BTN_RELEASE<=1. Otherwise dcnt++.
- Press latency: let edge E be the first edge that samples BTN_RAW=1, with the input stable from then on. BTN_PULSE is high for exactly the cycle after edge E+DEBOUNCE_CYCLES+1. Release latency is symmetric.
- Bounce tolerance: any s2 glitch shorter than DEBOUNCE_CYCLES samples produces no strobe and no level change, in either direction.
- Long press timing:
  - lcnt increments on every cycle spent in HELD or R_WAIT and saturates at LONG_CYCLES.
  - If BTN_PULSE is high in cycle T, BTN_LONG is high in cycle T+LONG_CYCLES, once per press (long_done set).
  - This holds only if the release has not been accepted before that cycle; a release glitch in R_WAIT does not reset lcnt.
- Simultaneous events:
  - If a release is accepted in the same cycle lcnt reaches LONG_CYCLES, the release wins and BTN_LONG is not asserted.
  - BTN_PULSE and BTN_RELEASE can never both be high in one cycle.
  - Consecutive strobes of the same kind are at least 2*DEBOUNCE_CYCLES cycles apart.
- Wrap-around: neither counter ever wraps. dcnt is bounded by the FSM, and lcnt saturates.

Test Plan:
- All tests use DEBOUNCE_CYCLES=4, LONG_CYCLES=20, CNT_W=8.
- Clean press: BTN_RAW 0->1 first sampled at edge 0 and held -> BTN_PULSE=1 only after edge 5; BTN_LEVEL=1 from edge 5 onward; no other strobe.
- Bounce: BTN_RAW toggles 1,0,1,1,0 on successive edges, then holds 1 from edge 10 -> no strobe before edge 15; single BTN_PULSE after edge 15.
- Release and short glitch:
  - From HELD, a 2-cycle low pulse on BTN_RAW -> no BTN_RELEASE, BTN_LEVEL stays 1.
  - Then hold 0 from edge R -> BTN_RELEASE one cycle after edge R+5, BTN_LEVEL=0.
- Long press: hold a press with BTN_PULSE in cycle T -> BTN_LONG in cycle T+20 only, once; keep holding 100 more cycles -> no further BTN_LONG.
- Release-beats-long: release timed so acceptance lands in cycle T+20 -> BTN_RELEASE=1, BTN_LONG=0 throughout.
- Async reset in HELD: drop RST_N between edges -> all outputs 0 before the next edge, no BTN_RELEASE. Raise RST_N with BTN_RAW still 1 -> fresh BTN_PULSE after DEBOUNCE_CYCLES+2 edges.
